ff_bank_universal: RTL and testbench
====================================

// Module: ff_bank_universal
// PURPOSE
//   WIDTH-bit bank of edge-triggered flip-flops. A single mode input selects D, T, JK or SR
//   behaviour, or a left/right shift, for all bits together. The block supersedes single-bit
//   D flip-flops wherever registers, toggle masks or shift chains are needed.
//   Every bit drives a Q output and a complementary Qbar output.
// PARAMETERS
//   WIDTH     8     number of flip-flops in the bank (>=2)
//   RESET_VAL 0     value q takes on reset (WIDTH bits)
// PORTS
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   en      in   1      clock enable; 0 = hold all state
//   mode    in   3      0 HOLD, 1 D, 2 T, 3 JK, 4 SR, 5 SHL, 6 SHR, 7 CLR
//   a       in   WIDTH  D data / T mask / J / S, depending on mode
//   b       in   WIDTH  K / R; ignored in other modes
//   si      in   1      serial input for SHL (enters bit 0) and SHR (enters bit WIDTH-1)
//   q       out  WIDTH  register state
//   qbar    out  WIDTH  ~q, always exactly complementary (combinational from q)
//   so      out  1      serial out: q[WIDTH-1] in SHL, q[0] in SHR, 0 in other modes (combinational)
//   sr_err  out  1      registered flag: an illegal SR combination occurred on the last enabled edge
// BEHAVIOUR
//   Reset
//     - rst_n low: q=RESET_VAL, qbar=~RESET_VAL, sr_err=0, immediately and independent of clk.
//     - Deassertion is taken synchronously by the user; the first active edge is the first clk rise
//       with rst_n high.
//     - Reset asserted mid-shift aborts the shift; no partial update.
//   Edge update (rising clk, rst_n=1, en=1); q_next per bit i:
//     - HOLD: q
//     - D:    a
//     - T:    q ^ a
//     - JK:   J=a, K=b; 00 hold, 01 ->0, 10 ->1, 11 toggle
//     - SR:   S=a, R=b; 00 hold, 01 ->0, 10 ->1, 11 hold (illegal)
//     - SHL:  {q[WIDTH-2:0], si}
//     - SHR:  {si, q[WIDTH-1:1]}
//     - CLR:  RESET_VAL (synchronous clear)
//   Timing
//     - Latency is one edge: q reflects the inputs sampled at edge N from edge N onward.
//     - en=0: q and sr_err hold their values. so tracks mode and q combinationally.
//   sr_err
//     - Set on an enabled edge in SR mode when any bit has a[i]&b[i]=1; otherwise cleared on
//       each enabled edge.
//     - Legal bits update normally in the same edge; only the illegal bits hold.
//   Boundary conditions
//     - WIDTH-bit wrap: SHL/SHR discard the outgoing bit. There is no rotate; rotation is
//       built with si=so externally.
//     - so is combinational, so si=so forms a rotate without a combinational loop.
//     - Mode changes take effect on the very edge they are sampled; no pipeline state carries
//       over between modes.
//   Implementation constraints
//     - All state lives in a single always block sensitive to posedge clk / negedge rst_n.
//     - No latches; qbar is never stored separately.
// TESTING
//   1. rst_n=0 mid-cycle with q=8'hA5 -> q=RESET_VAL (8'h00), qbar=8'hFF, sr_err=0 before the next clk edge.
//   2. D: mode=1, a=8'h3C, en=1 -> q=8'h3C after 1 edge. en=0, a=8'hFF -> q stays 8'h3C.
//   3. T/JK: q=8'h0F, mode=2, a=8'hFF -> q=8'hF0. mode=3, a=8'hF0, b=8'h0F -> q=8'hF0.
//      a=b=8'hFF -> q=8'h0F.
//   4. SR illegal: q=8'h00, mode=4, a=8'h81, b=8'h01 -> q=8'h80, sr_err=1.
//      Next edge with a=b=0 -> sr_err=0, q=8'h80.
//   5. Shift: q=8'h81, mode=5, si=0 -> q=8'h02 (so was 1).
//      mode=6, si=1 from q=8'h02 -> q=8'h81.
//      8 SHL edges with si=so restore the original q.
//   6. Random mode/a/b/en/rst_n for 10k cycles against a reference model;
//      qbar==~q checked every cycle.

Source files
------------

// File: rtl/ff_bank_universal.sv
// Purpose : WIDTH-bit flip-flop bank; mode selects D/T/JK/SR/shift-left/shift-right/clear for all bits.
// Latency : one clock edge from sampled inputs to q; qbar and so are combinational from q/mode.
// Backpressure: none; en=0 freezes q and sr_err, which is the only stall mechanism.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (q=RESET_VAL, sr_err=0)
//   en      clock enable, 0 holds all state
//   mode    0 HOLD, 1 D, 2 T, 3 JK, 4 SR, 5 SHL, 6 SHR, 7 CLR
//   a       D data / T mask / J / S
//   b       K / R
//   si      serial in: bit 0 on SHL, bit WIDTH-1 on SHR
//   q       register state
//   qbar    ~q
//   so      serial out: q[WIDTH-1] on SHL, q[0] on SHR, else 0
//   sr_err  set when the last enabled edge saw S=R=1 on any bit in SR mode

module ff_bank_universal #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             so,
    output logic             sr_err
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_D    = 3'd1,
        MODE_T    = 3'd2,
        MODE_JK   = 3'd3,
        MODE_SR   = 3'd4,
        MODE_SHL  = 3'd5,
        MODE_SHR  = 3'd6,
        MODE_CLR  = 3'd7
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             sr_err_q;
    logic             sr_err_d;
    logic [WIDTH-1:0] sr_set;
    logic [WIDTH-1:0] sr_rst;

    assign mode_s = mode_e'(mode);

    // SR: only the one-hot combinations act; S=R=1 falls into neither mask, so that bit holds.
    assign sr_set = a & ~b;
    assign sr_rst = b & ~a;

    always_comb begin
        q_d      = q_q;
        sr_err_d = 1'b0;
        case (mode_s)
            MODE_HOLD: q_d = q_q;
            MODE_D:    q_d = a;
            MODE_T:    q_d = q_q ^ a;
            // Characteristic equation Q+ = J&~Q | ~K&Q covers hold/reset/set/toggle.
            MODE_JK:   q_d = (a & ~q_q) | (~b & q_q);
            MODE_SR: begin
                q_d      = sr_set | (q_q & ~sr_rst);
                sr_err_d = |(a & b);
            end
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], si};
            MODE_SHR:  q_d = {si, q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = RESET_VAL;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= RESET_VAL;
            sr_err_q <= 1'b0;
        end else if (en) begin
            q_q      <= q_d;
            sr_err_q <= sr_err_d;
        end
    end

    // so depends only on current q and mode, never on si, so tying si=so cannot loop.
    always_comb begin
        so = 1'b0;
        case (mode_s)
            MODE_SHL: so = q_q[WIDTH-1];
            MODE_SHR: so = q_q[0];
            default:  so = 1'b0;
        endcase
    end

    assign q      = q_q;
    assign qbar   = ~q_q;
    assign sr_err = sr_err_q;

endmodule

// File: tb/tb_ff_bank_universal.sv
// Purpose : self-checking bench for ff_bank_universal (WIDTH=8, RESET_VAL=0).
// Latency : expected results queued at drive time, popped one edge later.
// Backpressure: n/a.
module tb_ff_bank_universal;

    localparam logic [2:0] M_HOLD = 3'd0, M_D = 3'd1, M_T = 3'd2, M_JK = 3'd3,
                           M_SR = 3'd4, M_SHL = 3'd5, M_SHR = 3'd6, M_CLR = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       si;
    logic [7:0] q;
    logic [7:0] qbar;
    logic       so;
    logic       sr_err;

    ff_bank_universal #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .si(si),
        .q(q), .qbar(qbar), .so(so), .sr_err(sr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       si;
        logic       exp_so;
        logic [7:0] exp_q;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       err;
        string      name;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] eq, input logic ee, input string name);
        exp_t e;
        e.q = eq; e.err = ee; e.name = name;
        sb.push_back(e);
    endtask

    // Called #1 after a rising edge: pops the oldest expectation and compares.
    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            chk({e.name, "_q"},    q,              e.q);
            chk({e.name, "_qbar"}, qbar,           ~e.q);
            chk({e.name, "_err"},  {7'd0, sr_err}, {7'd0, e.err});
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m,
                         input logic [7:0] av, input logic [7:0] bv, input logic s);
        @(negedge clk);
        rst_n = r; en = e; mode = m; a = av; b = bv; si = s;
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        pop_check();
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] cur, input logic [2:0] m,
                                            input logic [7:0] av, input logic [7:0] bv,
                                            input logic s);
        logic [7:0] n;
        n = cur;
        case (m)
            M_D: n = av;
            M_T: for (int i = 0; i < 8; i++) n[i] = av[i] ? ~cur[i] : cur[i];
            M_JK: for (int i = 0; i < 8; i++)
                case ({av[i], bv[i]})
                    2'b01:   n[i] = 1'b0;
                    2'b10:   n[i] = 1'b1;
                    2'b11:   n[i] = ~cur[i];
                    default: n[i] = cur[i];
                endcase
            M_SR: for (int i = 0; i < 8; i++)
                case ({av[i], bv[i]})
                    2'b01:   n[i] = 1'b0;
                    2'b10:   n[i] = 1'b1;
                    default: n[i] = cur[i];
                endcase
            M_SHL: n = {cur[6:0], s};
            M_SHR: n = {s, cur[7:1]};
            M_CLR: n = 8'h00;
            default: n = cur;
        endcase
        return n;
    endfunction

    function automatic logic ref_so(input logic [7:0] cur, input logic [2:0] m);
        if (m == M_SHL) return cur[7];
        if (m == M_SHR) return cur[0];
        return 1'b0;
    endfunction

    initial begin
        logic [7:0] mq;
        logic       merr;
        logic [7:0] nq;
        logic       nerr;
        logic [7:0] orig;

        //           en    mode    a      b      si    so    q      err
        vecs[0]  = '{1'b1, M_D,    8'h0F, 8'h00, 1'b0, 1'b0, 8'h0F, 1'b0};
        vecs[1]  = '{1'b1, M_T,    8'hFF, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0};
        vecs[2]  = '{1'b1, M_JK,   8'hF0, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0};
        vecs[3]  = '{1'b1, M_JK,   8'hFF, 8'hFF, 1'b0, 1'b0, 8'h0F, 1'b0};
        vecs[4]  = '{1'b1, M_D,    8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, M_SR,   8'h81, 8'h01, 1'b0, 1'b0, 8'h80, 1'b1};
        vecs[6]  = '{1'b1, M_SR,   8'h00, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0};
        vecs[7]  = '{1'b1, M_D,    8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[8]  = '{1'b0, M_D,    8'hFF, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[9]  = '{1'b1, M_D,    8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0};
        vecs[10] = '{1'b1, M_SHL,  8'h00, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0};
        vecs[11] = '{1'b1, M_SHR,  8'h00, 8'h00, 1'b1, 1'b0, 8'h81, 1'b0};
        vecs[12] = '{1'b1, M_CLR,  8'h5A, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{1'b1, M_SR,   8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b1};
        vecs[14] = '{1'b0, M_SR,   8'h00, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b1};
        vecs[15] = '{1'b1, M_HOLD, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hF0, 1'b0};
        vecs[16] = '{1'b1, M_SR,   8'h0F, 8'hF0, 1'b0, 1'b0, 8'h0F, 1'b0};

        rst_n = 1'b0; en = 1'b0; mode = M_HOLD; a = 8'h00; b = 8'h00; si = 1'b0;

        // Reset state, observed before any clock edge.
        #3;
        chk("reset_q",    q,              8'h00);
        chk("reset_qbar", qbar,           8'hFF);
        chk("reset_err",  {7'd0, sr_err}, 8'h00);
        chk("reset_so",   {7'd0, so},     8'h00);

        // Table-driven vectors; reset released at the first negedge.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].si);
            #1;
            chk($sformatf("vec%0d_so", i), {7'd0, so}, {7'd0, vecs[i].exp_so});
            push_exp(vecs[i].exp_q, vecs[i].exp_err, $sformatf("vec%0d", i));
            edge_check();
        end

        // Async reset mid-cycle with q=A5 and sr_err set.
        drive(1'b1, 1'b1, M_D, 8'hA5, 8'h00, 1'b0);
        push_exp(8'hA5, 1'b0, "load_a5");
        edge_check();
        drive(1'b1, 1'b1, M_SR, 8'h01, 8'h01, 1'b0);
        push_exp(8'hA5, 1'b1, "sr_illegal_hold");
        edge_check();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q",    q,              8'h00);
        chk("async_rst_qbar", qbar,           8'hFF);
        chk("async_rst_err",  {7'd0, sr_err}, 8'h00);

        // Reset held across an enabled edge keeps q at the reset value.
        drive(1'b0, 1'b1, M_D, 8'hFF, 8'h00, 1'b0);
        push_exp(8'h00, 1'b0, "rst_held");
        edge_check();

        // Rotate left via si=so: 8 edges restore the original value.
        orig = 8'hB4;
        drive(1'b1, 1'b1, M_D, orig, 8'h00, 1'b0);
        push_exp(orig, 1'b0, "load_rot");
        edge_check();
        mq = orig;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, M_SHL, 8'h00, 8'h00, 1'b0);
            #1;
            si = so;
            mq = {mq[6:0], mq[7]};
            push_exp(mq, 1'b0, $sformatf("rotl%0d", k));
            edge_check();
        end
        chk("rotl_restore", q, orig);

        // Rotate right via si=so.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, M_SHR, 8'h00, 8'h00, 1'b0);
            #1;
            si = so;
            mq = {mq[0], mq[7:1]};
            push_exp(mq, 1'b0, $sformatf("rotr%0d", k));
            edge_check();
        end
        chk("rotr_restore", q, orig);

        // Random run against the reference model.
        merr = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            logic       r_rst;
            logic       r_en;
            logic [2:0] r_mode;
            logic [7:0] r_a;
            logic [7:0] r_b;
            logic       r_si;
            r_rst  = ($urandom_range(0, 63) != 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_mode = 3'($urandom_range(0, 7));
            r_a    = 8'($urandom);
            r_b    = 8'($urandom);
            if ($urandom_range(0, 1) == 1) r_b = r_b & ~r_a;
            r_si   = 1'($urandom);
            drive(r_rst, r_en, r_mode, r_a, r_b, r_si);
            if (!r_rst) begin
                mq   = 8'h00;
                merr = 1'b0;
            end
            #1;
            chk("rand_so", {7'd0, so}, {7'd0, ref_so(mq, r_mode)});
            chk("rand_qbar_pre", qbar, ~q);
            nq = mq;
            nerr = merr;
            if (r_rst && r_en) begin
                nq   = ref_next(mq, r_mode, r_a, r_b, r_si);
                nerr = (r_mode == M_SR) && ((r_a & r_b) != 8'h00);
            end
            push_exp(nq, nerr, "rand");
            edge_check();
            mq   = nq;
            merr = nerr;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
